// File: rtl/y_arith_pkg.sv
//==============================================================================
// Module : y_arith_pkg
// Brief  : Shared control codes, FSM state encoding and sizing helper for
//          the serial add/subtract datapath.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package y_arith_pkg;

    localparam logic CTRL_ADD = 1'b0;
    localparam logic CTRL_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Slice counter width; never narrower than one bit so STEP == WIDTH still elaborates.
    function automatic int cnt_width(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

`default_nettype wire

// File: rtl/y_add_slice.sv
//==============================================================================
// Module : yAdder1 / y_add_slice
// Brief  : Single-bit full adder and a combinational STEP-bit ripple of them;
//          also exposes the carry into the slice MSB for overflow detection.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module yAdder1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module y_add_slice #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] i_a,
    input  logic [STEP-1:0] i_b,
    input  logic            i_cin,
    output logic [STEP-1:0] o_sum,
    output logic            o_cout,
    output logic            o_cmsb
);
    logic [STEP:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar i = 0; i < STEP; i++) begin : g_bit
            yAdder1 u_fa (
                .i_a    (i_a[i]),
                .i_b    (i_b[i]),
                .i_cin  (w_c[i]),
                .o_sum  (o_sum[i]),
                .o_cout (w_c[i+1])
            );
        end
    endgenerate

    assign o_cout = w_c[STEP];
    assign o_cmsb = w_c[STEP-1];
endmodule

`default_nettype wire

// File: rtl/y_serial_arith.sv
//==============================================================================
// Module : y_serial_arith
// Brief  : Multi-cycle WIDTH-bit add/subtract, STEP bits per clock, LSB first,
//          with start/busy/done handshake. Optional macro
//          Y_SERIAL_ARITH_ZERO_EN adds a registered zero-result flag.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module y_serial_arith
    import y_arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             cout,
    output logic             ovf
`ifdef Y_SERIAL_ARITH_ZERO_EN
    ,
    output logic             zero
`endif
);
    localparam int             NSLICE = WIDTH / STEP;
    localparam int             CW     = cnt_width(NSLICE);
    localparam logic [CW-1:0]  C_LAST = CW'(NSLICE - 1);

    generate
        if ((STEP < 1) || (WIDTH % STEP != 0)) begin : g_step_check
            $error("y_serial_arith: STEP must be >= 1 and divide WIDTH");
        end
    endgenerate

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;

    logic [STEP-1:0]  w_sum;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_acc_next;

    y_add_slice #(.STEP(STEP)) u_slice (
        .i_a    (r_opa[STEP-1:0]),
        .i_b    (r_opb[STEP-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    // New slice enters at the top so after NSLICE shifts the LSB slice sits at bit 0.
    generate
        if (STEP == WIDTH) begin : g_single
            assign w_acc_next = w_sum;
        end else begin : g_multi
            assign w_acc_next = {w_sum, r_acc[WIDTH-1:STEP]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            z       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
`ifdef Y_SERIAL_ARITH_ZERO_EN
            zero    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= (ctrl == CTRL_SUB) ? ~b : b;
                        r_carry <= ctrl;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_opa   <= r_opa >> STEP;
                    r_opb   <= r_opb >> STEP;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == C_LAST) begin
                        // Final slice: its MSB carry-in is the carry into bit WIDTH-1.
                        z       <= w_acc_next;
                        cout    <= w_cout;
                        ovf     <= w_cmsb ^ w_cout;
`ifdef Y_SERIAL_ARITH_ZERO_EN
                        zero    <= (w_acc_next == '0);
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_y_serial_arith.sv
//==============================================================================
// Module : tb_y_serial_arith
// Brief  : Scoreboard bench over five configurations of y_serial_arith
//          (W8/S1, W8/S2, W4/S1, W4/S2, W4/S4).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_y_serial_arith;

    typedef struct {
        int         dut;
        logic [7:0] z;
        logic       c;
        logic       v;
        logic       zr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] start;
    logic       ctrl;
    logic [7:0] a, b;
    logic [4:0] busy, done, cout, ovf, zero;
    logic [7:0] z0, z1;
    logic [3:0] z2, z3, z4;
    logic [7:0] zv [5];

    int NS [5] = '{8, 4, 4, 2, 1};
    int WD [5] = '{8, 8, 4, 4, 4};

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sbq [$];

    always #5 clk = ~clk;

    always_comb begin
        zv[0] = z0;
        zv[1] = z1;
        zv[2] = {4'b0, z2};
        zv[3] = {4'b0, z3};
        zv[4] = {4'b0, z4};
    end

`ifdef Y_SERIAL_ARITH_ZERO_EN
    `define ZPORT(i) , .zero(zero[i])
`else
    `define ZPORT(i)
    assign zero = '0;
`endif

    y_serial_arith #(.WIDTH(8), .STEP(1)) u_w8s1 (.clk(clk), .reset(reset), .start(start[0]), .ctrl(ctrl),
        .a(a), .b(b), .busy(busy[0]), .done(done[0]), .z(z0), .cout(cout[0]), .ovf(ovf[0]) `ZPORT(0));
    y_serial_arith #(.WIDTH(8), .STEP(2)) u_w8s2 (.clk(clk), .reset(reset), .start(start[1]), .ctrl(ctrl),
        .a(a), .b(b), .busy(busy[1]), .done(done[1]), .z(z1), .cout(cout[1]), .ovf(ovf[1]) `ZPORT(1));
    y_serial_arith #(.WIDTH(4), .STEP(1)) u_w4s1 (.clk(clk), .reset(reset), .start(start[2]), .ctrl(ctrl),
        .a(a[3:0]), .b(b[3:0]), .busy(busy[2]), .done(done[2]), .z(z2), .cout(cout[2]), .ovf(ovf[2]) `ZPORT(2));
    y_serial_arith #(.WIDTH(4), .STEP(2)) u_w4s2 (.clk(clk), .reset(reset), .start(start[3]), .ctrl(ctrl),
        .a(a[3:0]), .b(b[3:0]), .busy(busy[3]), .done(done[3]), .z(z3), .cout(cout[3]), .ovf(ovf[3]) `ZPORT(3));
    y_serial_arith #(.WIDTH(4), .STEP(4)) u_w4s4 (.clk(clk), .reset(reset), .start(start[4]), .ctrl(ctrl),
        .a(a[3:0]), .b(b[3:0]), .busy(busy[4]), .done(done[4]), .z(z4), .cout(cout[4]), .ovf(ovf[4]) `ZPORT(4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int d, input logic [7:0] zz, input logic c, input logic v);
        exp_t e;
        e.dut = d; e.z = zz; e.c = c; e.v = v; e.zr = (zz == 8'h00);
        return e;
    endfunction

    // Reference: {cout,z} = a + (ctrl ? ~b : b) + ctrl; ovf from true signed result range.
    function automatic exp_t model(input int d, input int w, input logic [7:0] av, input logic [7:0] bv, input logic ct);
        int m, ua, ub, ubn, s, sa, sb, r;
        m   = (1 << w) - 1;
        ua  = int'(av) & m;
        ub  = int'(bv) & m;
        ubn = ct ? (~ub & m) : ub;
        s   = ua + ubn + (ct ? 1 : 0);
        sa  = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb  = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        r   = ct ? sa - sb : sa + sb;
        return mk(d, 8'(s & m), 1'((s >> w) & 1),
                  (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1))));
    endfunction

    // Monitor: every done pulse consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            for (int i = 0; i < 5; i++) begin
                if (done[i]) begin
                    n_tests++;
                    if (sbq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_done: dut %0d z=%0h, no result expected", i, zv[i]);
                    end else begin
                        e = sbq.pop_front();
                        if (e.dut != i || zv[i] !== e.z || cout[i] !== e.c || ovf[i] !== e.v
`ifdef Y_SERIAL_ARITH_ZERO_EN
                            || zero[i] !== e.zr
`endif
                           ) begin
                            n_fail++;
                            $display("FAIL result: dut %0d got z=%0h c=%b v=%b zero=%b, expected dut %0d z=%0h c=%b v=%b zero=%b",
                                     i, zv[i], cout[i], ovf[i], zero[i], e.dut, e.z, e.c, e.v, e.zr);
                        end
                    end
                end
            end
        end
    end

    task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                          input logic ct, input exp_t e, input bit mid);
        int lat, bc;
        @(negedge clk);
        a = av; b = bv; ctrl = ct; start[d] = 1'b1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        lat = 0;
        bc  = 0;
        while (lat < 40) begin
            if (busy[d]) bc++;
            if (mid && lat == 2) begin
                a = 8'd1; b = 8'd1; start[d] = 1'b1;
            end else begin
                start[d] = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done[d]) break;
        end
        start[d] = 1'b0;
        chk($sformatf("latency_dut%0d", d), 32'(lat), 32'(NS[d]));
        chk($sformatf("busy_cycles_dut%0d", d), 32'(bc), 32'(NS[d]));
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b1; start = '0; ctrl = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_z",    {z0, z1, z2, z3, z4}, 0);
        chk("reset_cout", 32'(cout), 0);
        chk("reset_ovf",  32'(ovf), 0);
        chk("reset_zero", 32'(zero), 0);
        reset = 1'b0;

        run_op(0, 8'd100, 8'd27,  1'b0, mk(0, 8'd127, 1'b0, 1'b0), 1'b0);
        run_op(0, 8'd127, 8'd1,   1'b0, mk(0, 8'h80,  1'b0, 1'b1), 1'b0);
        run_op(0, 8'hFF,  8'h01,  1'b0, mk(0, 8'h00,  1'b1, 1'b0), 1'b0);
        run_op(1, 8'd5,   8'd7,   1'b1, mk(1, 8'hFE,  1'b0, 1'b0), 1'b0);
        run_op(1, 8'h80,  8'h01,  1'b1, mk(1, 8'h7F,  1'b1, 1'b1), 1'b0);
        run_op(0, 8'd20,  8'd30,  1'b0, mk(0, 8'd50,  1'b0, 1'b0), 1'b1);
        run_op(1, 8'd20,  8'd30,  1'b0, mk(1, 8'd50,  1'b0, 1'b0), 1'b1);

        // Abort in the third RUN cycle: no done may follow.
        @(negedge clk);
        a = 8'd10; b = 8'd3; ctrl = 1'b0; start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_done", 32'(done[0]), 0);
        chk("abort_z",    32'(z0), 0);
        repeat (12) @(posedge clk);
        run_op(0, 8'd10, 8'd3, 1'b0, mk(0, 8'd13, 1'b0, 1'b0), 1'b0);

        for (int d = 2; d < 5; d++)
            for (int av = 0; av < 16; av++)
                for (int bv = 0; bv < 16; bv++)
                    for (int ct = 0; ct < 2; ct++)
                        run_op(d, 8'(av), 8'(bv), 1'(ct), model(d, WD[d], 8'(av), 8'(bv), 1'(ct)), 1'b0);

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
